// File: rtl/button_event_decoder.sv
// Turns debounced push-button pulses into one-cycle short, double, long and auto-repeat events.
// Timing is measured in millisecond ticks produced by a clock prescaler.
module button_event_decoder #(
    parameter int unsigned TICK_DIV  = 50000,
    parameter int unsigned LONG_MS   = 800,
    parameter int unsigned DOUBLE_MS = 300,
    parameter int unsigned REPEAT_MS = 150
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pb_state,
    input  logic pb_down,
    input  logic pb_up,
    output logic short_press,
    output logic double_press,
    output logic long_press,
    output logic repeat_press,
    output logic busy
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] TickLast   = PW'(TICK_DIV - 1);
    localparam logic [15:0]   LongLast   = 16'(LONG_MS - 1);
    localparam logic [15:0]   DoubleLast = 16'(DOUBLE_MS - 1);
    localparam logic [15:0]   RepeatLast = 16'(REPEAT_MS - 1);
    localparam bit            RepeatEn   = (REPEAT_MS != 0);

    typedef enum logic [2:0] {
        StIdle,
        StPressed,
        StLongHeld,
        StWaitSecond,
        StSecondPressed
    } state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] presc_q;
    logic [15:0]   ms_q;
    logic          tick;
    logic          released;
    logic          clr;
    logic          short_d, double_d, long_d, repeat_d;
    logic          short_q, double_q, long_q, repeat_q, busy_q;

    assign tick     = (presc_q == TickLast);
    // A dropped level also counts as release in case the pb_up pulse was missed.
    assign released = pb_up | ~pb_state;

    always_comb begin
        state_d  = state_q;
        short_d  = 1'b0;
        double_d = 1'b0;
        long_d   = 1'b0;
        repeat_d = 1'b0;
        case (state_q)
            StIdle: begin
                if (pb_down) state_d = StPressed;
            end
            StPressed: begin
                if (released) begin
                    state_d = StWaitSecond;
                end else if (tick && ms_q == LongLast) begin
                    long_d  = 1'b1;
                    state_d = StLongHeld;
                end
            end
            StLongHeld: begin
                if (released) begin
                    state_d = StIdle;
                end else if (RepeatEn && tick && ms_q == RepeatLast) begin
                    repeat_d = 1'b1;
                end
            end
            StWaitSecond: begin
                if (pb_down) begin
                    state_d = StSecondPressed;
                end else if (tick && ms_q == DoubleLast) begin
                    short_d = 1'b1;
                    state_d = StIdle;
                end
            end
            StSecondPressed: begin
                if (released) begin
                    double_d = 1'b1;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        clr = (state_d != state_q) | repeat_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            presc_q  <= '0;
            ms_q     <= '0;
            short_q  <= 1'b0;
            double_q <= 1'b0;
            long_q   <= 1'b0;
            repeat_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            short_q  <= short_d;
            double_q <= double_d;
            long_q   <= long_d;
            repeat_q <= repeat_d;
            busy_q   <= (state_d != StIdle);
            if (clr) begin
                presc_q <= '0;
                ms_q    <= '0;
            end else if (tick) begin
                presc_q <= '0;
                if (ms_q != 16'hFFFF) ms_q <= ms_q + 16'd1;
            end else begin
                presc_q <= presc_q + PW'(1);
            end
        end
    end

    assign short_press  = short_q;
    assign double_press = double_q;
    assign long_press   = long_q;
    assign repeat_press = repeat_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_button_event_decoder.sv
// Bench for button_event_decoder: one instance with auto-repeat, one with repeat disabled,
// both driven by the same button stimulus and checked against scheduled event queues.
module tb_button_event_decoder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic pb_state = 1'b0;
    logic pb_down = 1'b0;
    logic pb_up = 1'b0;
    logic a_short, a_double, a_long, a_repeat, a_busy;
    logic b_short, b_double, b_long, b_repeat, b_busy;

    always #5 clk = ~clk;

    button_event_decoder #(
        .TICK_DIV(4), .LONG_MS(10), .DOUBLE_MS(5), .REPEAT_MS(3)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .pb_state(pb_state), .pb_down(pb_down), .pb_up(pb_up),
        .short_press(a_short), .double_press(a_double), .long_press(a_long),
        .repeat_press(a_repeat), .busy(a_busy)
    );

    button_event_decoder #(
        .TICK_DIV(4), .LONG_MS(10), .DOUBLE_MS(5), .REPEAT_MS(0)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .pb_state(pb_state), .pb_down(pb_down), .pb_up(pb_up),
        .short_press(b_short), .double_press(b_double), .long_press(b_long),
        .repeat_press(b_repeat), .busy(b_busy)
    );

    // Event kinds: 1 short, 2 double, 3 long, 4 repeat.
    typedef struct {
        int kind;
        int t;
    } ev_t;

    typedef struct {
        string name;
        int    dn1, up1, dn2, up2;
        bit    missed;
        int    len;
        int    long_t, rep_first, rep_last, short_t, double_t, busy_end;
    } vec_t;

    ev_t  qa[$];
    ev_t  qb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   rel = 0;
    vec_t vecs[7];

    task automatic step(input logic dn, input logic up, input logic st, input logic rst);
        pb_down  = dn;
        pb_up    = up;
        pb_state = st;
        rst_n    = rst;
        @(posedge clk);
        #1;
        rel++;
    endtask

    task automatic check_ev(input int id, input logic s, input logic d, input logic l,
                            input logic r);
        int  got;
        int  n;
        int  qs;
        ev_t e;
        n   = int'(s) + int'(d) + int'(l) + int'(r);
        got = s ? 1 : d ? 2 : l ? 3 : r ? 4 : 0;
        qs  = (id == 0) ? qa.size() : qb.size();
        if (n > 1) begin
            n_cmp++;
            n_bad++;
            $display("FAIL onehot dut%0d t=%0d: %0d pulses high, required at most 1", id, rel, n);
        end
        if (got != 0) begin
            n_cmp++;
            if (qs == 0) begin
                n_bad++;
                $display("FAIL unexpected dut%0d t=%0d: event kind %0d, required none", id, rel,
                         got);
            end else begin
                if (id == 0) e = qa.pop_front();
                else e = qb.pop_front();
                if (e.kind != got || e.t != rel) begin
                    n_bad++;
                    $display("FAIL event dut%0d: got kind %0d at t=%0d, required kind %0d at t=%0d",
                             id, got, rel, e.kind, e.t);
                end
            end
        end else if (qs > 0) begin
            e = (id == 0) ? qa[0] : qb[0];
            if (e.t <= rel) begin
                n_cmp++;
                n_bad++;
                if (id == 0) void'(qa.pop_front());
                else void'(qb.pop_front());
                $display("FAIL missing dut%0d t=%0d: no pulse, required kind %0d", id, rel, e.kind);
            end
        end
    endtask

    task automatic check_all_events();
        check_ev(0, a_short, a_double, a_long, a_repeat);
        check_ev(1, b_short, b_double, b_long, b_repeat);
    endtask

    task automatic check_busy(input logic exp);
        n_cmp++;
        if (a_busy !== exp || b_busy !== exp) begin
            n_bad++;
            $display("FAIL busy t=%0d: a=%b b=%b, required %b", rel, a_busy, b_busy, exp);
        end
    endtask

    task automatic check_drained(input string name);
        n_cmp++;
        if (qa.size() != 0 || qb.size() != 0) begin
            n_bad++;
            $display("FAIL drained %s: %0d/%0d events outstanding, required 0", name, qa.size(),
                     qb.size());
        end
        qa.delete();
        qb.delete();
    endtask

    task automatic push(input int kind, input int t, input bit to_b);
        ev_t e;
        e.kind = kind;
        e.t    = t;
        qa.push_back(e);
        if (to_b) qb.push_back(e);
    endtask

    initial begin
        logic dn, up, st, rst, exp_b;
        vecs[0] = '{"short",    0, 12, -1, -1, 1'b0,  45,  0,  0,   0, 33,  0,  33};
        vecs[1] = '{"double",   0,  8, 20, 30, 1'b0,  45,  0,  0,   0,  0, 31,  31};
        vecs[2] = '{"long_rep", 0, 100, -1, -1, 1'b0, 130, 41, 53,  89,  0,  0, 101};
        vecs[3] = '{"boundary", 0, 40, -1, -1, 1'b0,  75,  0,  0,   0, 61,  0,  61};
        vecs[4] = '{"dn_at_to", 0,  8, 28, 35, 1'b0,  60,  0,  0,   0,  0, 36,  36};
        vecs[5] = '{"long_200", 0, 200, -1, -1, 1'b0, 230, 41, 53, 197,  0,  0, 201};
        vecs[6] = '{"missed",   0, 12, -1, -1, 1'b1,  45,  0,  0,   0, 33,  0,  33};

        // Reset state, including a pulse on pb_down while reset is held.
        step(1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if ({a_short, a_double, a_long, a_repeat, a_busy} !== 5'b0) begin
            n_bad++;
            $display("FAIL reset_a: outputs %b, required 00000",
                     {a_short, a_double, a_long, a_repeat, a_busy});
        end
        n_cmp++;
        if ({b_short, b_double, b_long, b_repeat, b_busy} !== 5'b0) begin
            n_bad++;
            $display("FAIL reset_b: outputs %b, required 00000",
                     {b_short, b_double, b_long, b_repeat, b_busy});
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b1);
            check_all_events();
        end

        foreach (vecs[v]) begin
            if (vecs[v].long_t != 0) push(3, vecs[v].long_t, 1'b1);
            if (vecs[v].rep_first != 0)
                for (int t = vecs[v].rep_first; t <= vecs[v].rep_last; t += 12) push(4, t, 1'b0);
            if (vecs[v].short_t != 0) push(1, vecs[v].short_t, 1'b1);
            if (vecs[v].double_t != 0) push(2, vecs[v].double_t, 1'b1);
            rel = 0;
            for (int c = 0; c < vecs[v].len; c++) begin
                dn = (c == vecs[v].dn1) || (c == vecs[v].dn2);
                up = !vecs[v].missed && ((c == vecs[v].up1) || (c == vecs[v].up2));
                st = (c >= vecs[v].dn1 && c < vecs[v].up1) || (c >= vecs[v].dn2 && c < vecs[v].up2);
                step(dn, up, st, 1'b1);
                check_all_events();
                check_busy(rel >= 1 && rel < vecs[v].busy_end);
            end
            check_drained(vecs[v].name);
            for (int i = 0; i < 5; i++) begin
                step(1'b0, 1'b0, 1'b0, 1'b1);
                check_all_events();
            end
        end

        // Reset mid-PRESSED with the button still held, then a clean short press.
        rel = 0;
        push(1, 76, 1'b1);
        for (int c = 0; c < 86; c++) begin
            dn  = (c == 0) || (c == 50);
            up  = (c == 40) || (c == 55);
            st  = (c < 40) || (c >= 50 && c < 55);
            rst = !(c >= 20 && c < 25);
            if (c == 20) begin
                rst_n = 1'b0;
                #1;
                check_busy(1'b0);
            end
            step(dn, up, st, rst);
            check_all_events();
            exp_b = (rel >= 1 && rel <= 20) || (rel >= 51 && rel < 76);
            check_busy(exp_b);
        end
        check_drained("reset_mid");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
